// File: rtl/pipe_front_regs.sv
// Front-end pipeline state for the five-stage core: fetch PC, IF/ID and
// ID/EX registers, plus saturating stall/flush event counters. Applies the
// stall, flush and redirect decisions made by the hazard unit.
module pipe_front_regs #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013,
    parameter int               CTRL_W    = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              stall_f_i,
    input  logic              stall_d_i,
    input  logic              flush_d_i,
    input  logic              flush_e_i,
    input  logic              pc_src_e_i,
    input  logic [XLEN-1:0]   pc_target_e_i,
    input  logic [31:0]       instr_f_i,
    input  logic [XLEN-1:0]   rd1_d_i,
    input  logic [XLEN-1:0]   rd2_d_i,
    input  logic [XLEN-1:0]   imm_ext_d_i,
    input  logic [CTRL_W-1:0] ctrl_d_i,
    output logic [XLEN-1:0]   pc_f_o,
    output logic [31:0]       instr_d_o,
    output logic [XLEN-1:0]   pc_d_o,
    output logic [XLEN-1:0]   pc_plus4_d_o,
    output logic              valid_d_o,
    output logic [4:0]        rs1_d_o,
    output logic [4:0]        rs2_d_o,
    output logic [XLEN-1:0]   rd1_e_o,
    output logic [XLEN-1:0]   rd2_e_o,
    output logic [XLEN-1:0]   imm_ext_e_o,
    output logic [XLEN-1:0]   pc_e_o,
    output logic [XLEN-1:0]   pc_plus4_e_o,
    output logic [4:0]        rs1_e_o,
    output logic [4:0]        rs2_e_o,
    output logic [4:0]        rd_e_o,
    output logic [CTRL_W-1:0] ctrl_e_o,
    output logic              valid_e_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [31:0]     CNT_MAX = 32'hFFFF_FFFF;

    // Sequential PC; the adder wraps naturally at all-ones.
    logic [XLEN-1:0] pc_plus4_f;
    assign pc_plus4_f = pc_f_o + PC_STEP;

    // Source register indices are plain slices of the decode instruction.
    assign rs1_d_o = instr_d_o[19:15];
    assign rs2_d_o = instr_d_o[24:20];

    // Fetch PC: a redirect from Execute wins over a fetch stall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_f_o <= RESET_PC;
        end else if (pc_src_e_i) begin
            pc_f_o <= pc_target_e_i;
        end else if (!stall_f_i) begin
            pc_f_o <= pc_plus4_f;
        end
    end

    // IF/ID: a flush inserts a bubble even while the stage is stalled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instr_d_o    <= NOP_INSTR;
            pc_d_o       <= '0;
            pc_plus4_d_o <= '0;
            valid_d_o    <= 1'b0;
        end else if (flush_d_i) begin
            instr_d_o    <= NOP_INSTR;
            pc_d_o       <= '0;
            pc_plus4_d_o <= '0;
            valid_d_o    <= 1'b0;
        end else if (!stall_d_i) begin
            instr_d_o    <= instr_f_i;
            pc_d_o       <= pc_f_o;
            pc_plus4_d_o <= pc_plus4_f;
            valid_d_o    <= 1'b1;
        end
    end

    // ID/EX: never stalls; a flush clears the whole control bundle so the
    // bubble cannot write registers or memory.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd1_e_o      <= '0;
            rd2_e_o      <= '0;
            imm_ext_e_o  <= '0;
            pc_e_o       <= '0;
            pc_plus4_e_o <= '0;
            rs1_e_o      <= '0;
            rs2_e_o      <= '0;
            rd_e_o       <= '0;
            ctrl_e_o     <= '0;
            valid_e_o    <= 1'b0;
        end else if (flush_e_i) begin
            rd1_e_o      <= '0;
            rd2_e_o      <= '0;
            imm_ext_e_o  <= '0;
            pc_e_o       <= '0;
            pc_plus4_e_o <= '0;
            rs1_e_o      <= '0;
            rs2_e_o      <= '0;
            rd_e_o       <= '0;
            ctrl_e_o     <= '0;
            valid_e_o    <= 1'b0;
        end else begin
            rd1_e_o      <= rd1_d_i;
            rd2_e_o      <= rd2_d_i;
            imm_ext_e_o  <= imm_ext_d_i;
            pc_e_o       <= pc_d_o;
            pc_plus4_e_o <= pc_plus4_d_o;
            rs1_e_o      <= rs1_d_o;
            rs2_e_o      <= rs2_d_o;
            rd_e_o       <= instr_d_o[11:7];
            ctrl_e_o     <= ctrl_d_i;
            valid_e_o    <= valid_d_o;
        end
    end

    // Event counters; a stall that is overridden by a flush is not counted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_d_i && !flush_d_i && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (flush_e_i && (flush_cnt_o != CNT_MAX)) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: stage-level reference model compared every
// cycle, plus directed literal expectations queued per clock edge.
module tb_pipe_front_regs;

    localparam int          XLEN   = 32;
    localparam int          CTRL_W = 12;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] MAXV   = 32'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT connections ----------------
    logic              stall_f, stall_d, flush_d, flush_e, pc_src;
    logic [31:0]       pc_target, instr_f, rd1_d, rd2_d, imm_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic [31:0]       pc_f, instr_d, pc_d, pc4_d, rd1_e, rd2_e, imm_e, pc_e, pc4_e;
    logic [31:0]       stall_cnt, flush_cnt;
    logic              valid_d, valid_e;
    logic [4:0]        rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic [CTRL_W-1:0] ctrl_e;

    pipe_front_regs #(.XLEN(XLEN), .RESET_PC(32'h0), .NOP_INSTR(NOP), .CTRL_W(CTRL_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .stall_f_i(stall_f), .stall_d_i(stall_d), .flush_d_i(flush_d), .flush_e_i(flush_e),
        .pc_src_e_i(pc_src), .pc_target_e_i(pc_target), .instr_f_i(instr_f),
        .rd1_d_i(rd1_d), .rd2_d_i(rd2_d), .imm_ext_d_i(imm_d), .ctrl_d_i(ctrl_d),
        .pc_f_o(pc_f), .instr_d_o(instr_d), .pc_d_o(pc_d), .pc_plus4_d_o(pc4_d),
        .valid_d_o(valid_d), .rs1_d_o(rs1_d), .rs2_d_o(rs2_d),
        .rd1_e_o(rd1_e), .rd2_e_o(rd2_e), .imm_ext_e_o(imm_e), .pc_e_o(pc_e),
        .pc_plus4_e_o(pc4_e), .rs1_e_o(rs1_e), .rs2_e_o(rs2_e), .rd_e_o(rd_e),
        .ctrl_e_o(ctrl_e), .valid_e_o(valid_e),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    // Small instruction memory indexed by PC word; first three words are
    // addi x1,x0,5, the rest carry distinct rs1/rs2/rd fields.
    logic [31:0] imem [16];
    initial begin
        logic [4:0] a, b, c;
        for (int i = 0; i < 16; i++) begin
            a = 5'(i);
            b = 5'(i + 7);
            c = 5'(i + 2);
            imem[i] = (i < 3) ? 32'h0050_0093 : {7'b0, b, a, 3'b000, c, 7'h13};
        end
    end
    assign instr_f = imem[pc_f[5:2]];

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    int          sel_q[$];
    int preload_seq  = 0;
    int preload_seen = 0;

    localparam int S_PC = 0, S_INSTR_D = 1, S_VALID_D = 2, S_VALID_E = 3, S_RD_E = 4,
                   S_CTRL_E = 5, S_SCNT = 6, S_FCNT = 7, S_PC4_D = 8, S_PC_E = 9, S_PC_D = 10;

    function automatic string sig_name(input int s);
        case (s)
            S_PC:      return "lit_pc_f";
            S_INSTR_D: return "lit_instr_d";
            S_VALID_D: return "lit_valid_d";
            S_VALID_E: return "lit_valid_e";
            S_RD_E:    return "lit_rd_e";
            S_CTRL_E:  return "lit_ctrl_e";
            S_SCNT:    return "lit_stall_cnt";
            S_FCNT:    return "lit_flush_cnt";
            S_PC4_D:   return "lit_pc_plus4_d";
            S_PC_E:    return "lit_pc_e";
            default:   return "lit_pc_d";
        endcase
    endfunction

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            S_PC:      return pc_f;
            S_INSTR_D: return instr_d;
            S_VALID_D: return {31'b0, valid_d};
            S_VALID_E: return {31'b0, valid_e};
            S_RD_E:    return {27'b0, rd_e};
            S_CTRL_E:  return {20'b0, ctrl_e};
            S_SCNT:    return stall_cnt;
            S_FCNT:    return flush_cnt;
            S_PC4_D:   return pc4_d;
            S_PC_E:    return pc_e;
            default:   return pc_d;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instr, pc, pc4;
        logic        valid;
    } dec_t;
    typedef struct packed {
        logic [31:0]       rd1, rd2, imm, pc, pc4;
        logic [4:0]        rs1, rs2, rd;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } exe_t;

    logic [31:0] m_pc;
    dec_t        m_d;
    exe_t        m_e;
    logic [31:0] m_scnt, m_fcnt;

    // One compare process: advance the model on each edge, then check the
    // DUT against it and drain any literal expectations queued for the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0;
            m_d  = '{instr: NOP, pc: 32'h0, pc4: 32'h0, valid: 1'b0};
            m_e  = '0;
            m_scnt = 32'h0;
            m_fcnt = 32'h0;
        end else begin
            if (preload_seq != preload_seen) begin
                preload_seen = preload_seq;
                m_scnt = 32'hFFFF_FFFE;
            end
            if (stall_d && !flush_d && m_scnt != MAXV) m_scnt = m_scnt + 1;
            if (flush_e && m_fcnt != MAXV) m_fcnt = m_fcnt + 1;
            // Execute takes whatever Decode presents this cycle.
            if (flush_e) m_e = '0;
            else m_e = '{rd1: rd1_d, rd2: rd2_d, imm: imm_d, pc: m_d.pc, pc4: m_d.pc4,
                         rs1: m_d.instr[19:15], rs2: m_d.instr[24:20], rd: m_d.instr[11:7],
                         ctrl: ctrl_d, valid: m_d.valid};
            // Decode takes the fetched word unless bubbled or held.
            if (flush_d) m_d = '{instr: NOP, pc: 32'h0, pc4: 32'h0, valid: 1'b0};
            else if (!stall_d) m_d = '{instr: imem[m_pc[5:2]], pc: m_pc, pc4: m_pc + 32'd4, valid: 1'b1};
            // Fetch.
            if (pc_src) m_pc = pc_target;
            else if (!stall_f) m_pc = m_pc + 32'd4;
        end
        #1;
        chk("pc_f", pc_f, m_pc);
        chk("instr_d", instr_d, m_d.instr);
        chk("pc_d", pc_d, m_d.pc);
        chk("pc_plus4_d", pc4_d, m_d.pc4);
        chk("valid_d", {31'b0, valid_d}, {31'b0, m_d.valid});
        chk("rs1_d", {27'b0, rs1_d}, {27'b0, m_d.instr[19:15]});
        chk("rs2_d", {27'b0, rs2_d}, {27'b0, m_d.instr[24:20]});
        chk("rd1_e", rd1_e, m_e.rd1);
        chk("rd2_e", rd2_e, m_e.rd2);
        chk("imm_e", imm_e, m_e.imm);
        chk("pc_e", pc_e, m_e.pc);
        chk("pc_plus4_e", pc4_e, m_e.pc4);
        chk("rs1_e", {27'b0, rs1_e}, {27'b0, m_e.rs1});
        chk("rs2_e", {27'b0, rs2_e}, {27'b0, m_e.rs2});
        chk("rd_e", {27'b0, rd_e}, {27'b0, m_e.rd});
        chk("ctrl_e", {20'b0, ctrl_e}, {20'b0, m_e.ctrl});
        chk("valid_e", {31'b0, valid_e}, {31'b0, m_e.valid});
        chk("stall_cnt", stall_cnt, m_scnt);
        chk("flush_cnt", flush_cnt, m_fcnt);
        while (sel_q.size() > 0) begin
            int s;
            logic [31:0] e;
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            chk(sig_name(s), sig_val(s), e);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic lit(input int s, input logic [31:0] v);
        sel_q.push_back(s);
        exp_q.push_back(v);
    endtask

    // Apply one cycle of hazard controls (Decode data randomised), then
    // wait until the following falling edge.
    task automatic step(input logic sf, input logic sd, input logic fd,
                        input logic fe, input logic ps, input logic [31:0] tgt);
        stall_f   = sf;
        stall_d   = sd;
        flush_d   = fd;
        flush_e   = fe;
        pc_src    = ps;
        pc_target = tgt;
        rd1_d     = $urandom;
        rd2_d     = $urandom;
        imm_d     = $urandom;
        ctrl_d    = CTRL_W'($urandom_range(1, 4095));
        @(negedge clk);
    endtask

    task automatic preload_stall_cnt();
        force dut.stall_cnt_o = 32'hFFFF_FFFE;
        preload_seq++;
        #1;
        release dut.stall_cnt_o;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        stall_f = 0; stall_d = 0; flush_d = 0; flush_e = 0; pc_src = 0;
        pc_target = 0; rd1_d = 0; rd2_d = 0; imm_d = 0; ctrl_d = 0;
        // reset values
        lit(S_PC, 32'h0); lit(S_INSTR_D, NOP); lit(S_VALID_D, 0); lit(S_VALID_E, 0);
        lit(S_SCNT, 0); lit(S_FCNT, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // fetch 0,4,8 and propagation into Decode/Execute
        lit(S_PC, 32'h4); lit(S_INSTR_D, 32'h0050_0093);
        step(0, 0, 0, 0, 0, 0);
        lit(S_PC, 32'h8); lit(S_RD_E, 32'd1); lit(S_VALID_E, 1);
        step(0, 0, 0, 0, 0, 0);
        // load-use at pc 8
        lit(S_PC, 32'h8); lit(S_INSTR_D, 32'h0050_0093); lit(S_PC_D, 32'h4);
        lit(S_CTRL_E, 0); lit(S_VALID_E, 0); lit(S_SCNT, 1); lit(S_FCNT, 1);
        step(1, 1, 0, 1, 0, 0);
        lit(S_PC, 32'hC); lit(S_VALID_E, 1); lit(S_PC_E, 32'h4); lit(S_PC_D, 32'h8);
        step(0, 0, 0, 0, 0, 0);
        // redirect with simultaneous stalls
        lit(S_PC, 32'h100); lit(S_INSTR_D, NOP); lit(S_VALID_D, 0); lit(S_VALID_E, 0);
        lit(S_SCNT, 1); lit(S_FCNT, 2);
        step(1, 1, 1, 1, 1, 32'h100);
        lit(S_PC, 32'h104); lit(S_PC_D, 32'h100); lit(S_VALID_E, 0);
        step(0, 0, 0, 0, 0, 0);
        // PC wrap
        lit(S_PC, 32'hFFFF_FFFC); lit(S_FCNT, 3);
        step(0, 0, 1, 1, 1, 32'hFFFF_FFFC);
        lit(S_PC, 32'h0); lit(S_PC4_D, 32'h0); lit(S_PC_D, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0);
        lit(S_PC, 32'h4); lit(S_PC_E, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0);
        // held stall for three cycles: no drift
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        lit(S_PC, 32'h4); lit(S_PC_D, 32'h0); lit(S_SCNT, 4);
        step(1, 1, 0, 0, 0, 0);
        // Decode-only stall, then a flush that overrides a stall
        lit(S_PC, 32'h8); lit(S_SCNT, 5);
        step(0, 1, 0, 0, 0, 0);
        lit(S_SCNT, 5); lit(S_VALID_D, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // stall counter saturation
        preload_stall_cnt();
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        lit(S_SCNT, MAXV);
        step(1, 1, 0, 0, 0, 0);
        // asynchronous reset in the middle of a stall
        stall_f = 1; stall_d = 1;
        @(posedge clk);
        #2;
        lit(S_PC, 32'h0); lit(S_INSTR_D, NOP); lit(S_VALID_D, 0); lit(S_VALID_E, 0);
        lit(S_RD_E, 0); lit(S_SCNT, 0); lit(S_FCNT, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lit(S_PC, 32'h4); lit(S_VALID_D, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
